// File: rtl/aes128_key_expander_if.sv
// ----------------------------------------------------------------------------
// aes128_key_expander_if
//   Bundles the key-load handshake, the SubWord side channel and the round-key
//   read port of aes128_key_expander.
//
//   master : the surrounding system (key source, SubWord instance, CTR core)
//   slave  : the key expander itself
//
//   Signals
//     key_in[127:0]      cipher key, key_in[127:96] = w[0]
//     key_valid          key_in valid, accepted on key_valid & key_ready
//     key_ready          expander can take a new key (IDLE or DONE)
//     busy               expansion in progress
//     done               one-cycle pulse after the last word is written
//     keys_valid         all 11 round keys hold a complete schedule
//     sub_word_in[31:0]  RotWord(w[i-1]) towards the external SubWord
//     sub_word_out[31:0] SubWord result, combinational in the same cycle
//     rk_addr[3:0]       round key index 0..10
//     rk_data[127:0]     round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//     zeroize            storage wipe, present only with AES_KEYEXP_ZEROIZE_EN
// ----------------------------------------------------------------------------
interface aes128_key_expander_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [31:0]  sub_word_in;
    logic [31:0]  sub_word_out;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
`ifdef AES_KEYEXP_ZEROIZE_EN
    logic         zeroize;

    modport master (
        output key_in, key_valid, sub_word_out, rk_addr, zeroize,
        input  key_ready, busy, done, keys_valid, sub_word_in, rk_data
    );
    modport slave (
        input  key_in, key_valid, sub_word_out, rk_addr, zeroize,
        output key_ready, busy, done, keys_valid, sub_word_in, rk_data
    );
`else
    modport master (
        output key_in, key_valid, sub_word_out, rk_addr,
        input  key_ready, busy, done, keys_valid, sub_word_in, rk_data
    );
    modport slave (
        input  key_in, key_valid, sub_word_out, rk_addr,
        output key_ready, busy, done, keys_valid, sub_word_in, rk_data
    );
`endif
endinterface

// File: rtl/aes128_key_expander.sv
// ----------------------------------------------------------------------------
// aes128_key_expander
//   Sequential AES-128 key schedule. Expands a 128-bit key into 44 words
//   (11 round keys), one word per clock, using an external combinational
//   SubWord fed with RotWord(w[i-1]). All round keys stay stored for
//   random-access reads by the round datapath.
//
//   Parameters
//     RK_REG_OUT  1: rk_data registered (1-cycle read latency)
//                 0: rk_data combinational
//   Macros
//     AES_KEYEXP_ZEROIZE_EN  adds bus.zeroize, which wipes the schedule
//   Ports
//     clk   system clock, rising edge
//     rst   asynchronous reset, active-high
//     bus   aes128_key_expander_if.slave (handshake, SubWord, round-key read)
// ----------------------------------------------------------------------------
module aes128_key_expander #(
    parameter bit RK_REG_OUT = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    aes128_key_expander_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;

    logic [31:0]  w [0:43];
    logic [5:0]   idx;
    logic [7:0]   rcon;
    logic         done_q;
    logic         keys_valid_q;

    logic         zeroize_hit;
    logic         accept;
    logic         expanding;
    logic         last_word;
    logic [5:0]   idx_prev;
    logic [5:0]   idx_back4;
    logic [31:0]  w_prev;
    logic [31:0]  temp;
    logic [5:0]   rk_base;
    logic [127:0] rk_comb;

    // GF(2^8) multiply by x, used to step the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef AES_KEYEXP_ZEROIZE_EN
    assign zeroize_hit = bus.zeroize;
`else
    assign zeroize_hit = 1'b0;
`endif

    assign expanding = (state == ST_EXPAND);
    // A key offered during EXPAND is dropped, not queued; zeroize wins.
    assign accept    = bus.key_valid && !expanding && !zeroize_hit;
    assign last_word = expanding && (idx == 6'd43);

    // Outside EXPAND idx may be 0, so reads are parked on word 0.
    assign idx_prev  = expanding ? idx - 6'd1 : 6'd0;
    assign idx_back4 = expanding ? idx - 6'd4 : 6'd0;
    assign w_prev    = w[idx_prev];

    assign bus.sub_word_in = expanding ? {w_prev[23:0], w_prev[31:24]} : 32'h0;
    assign temp = (idx[1:0] == 2'b00) ? (bus.sub_word_out ^ {rcon, 24'h0}) : w_prev;

    assign bus.key_ready  = !expanding;
    assign bus.busy       = expanding;
    assign bus.done       = done_q;
    assign bus.keys_valid = keys_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        if (zeroize_hit) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (accept)    state_next = ST_EXPAND;
                ST_EXPAND:        if (last_word) state_next = ST_DONE;
                default:                         state_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: the word store is reset explicitly; reset must present an
    // all-zero schedule, so it cannot be left as an unreset RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 44; i++) w[i] <= 32'h0;
            idx          <= 6'd0;
            rcon         <= 8'h01;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (zeroize_hit) begin
                for (int i = 0; i < 44; i++) w[i] <= 32'h0;
                idx          <= 6'd0;
                rcon         <= 8'h01;
                keys_valid_q <= 1'b0;
            end else if (accept) begin
                w[0]         <= bus.key_in[127:96];
                w[1]         <= bus.key_in[95:64];
                w[2]         <= bus.key_in[63:32];
                w[3]         <= bus.key_in[31:0];
                idx          <= 6'd4;
                rcon         <= 8'h01;
                keys_valid_q <= 1'b0;
            end else if (expanding) begin
                w[idx] <= w[idx_back4] ^ temp;
                idx    <= idx + 6'd1;
                if (idx[1:0] == 2'b00) rcon <= xtime(rcon);
                if (last_word) begin
                    done_q       <= 1'b1;
                    keys_valid_q <= 1'b1;
                end
            end
        end
    end

    // Round-key read; indices 11..15 return zero.
    always_comb begin
        rk_base = {rk_addr_q(), 2'b00};
        rk_comb = 128'h0;
        if (bus.rk_addr <= 4'd10)
            rk_comb = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    end

    function automatic logic [3:0] rk_addr_q();
        return (bus.rk_addr <= 4'd10) ? bus.rk_addr : 4'd0;
    endfunction

    generate
        if (RK_REG_OUT) begin : g_rk_reg
            logic [127:0] rk_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) rk_q <= 128'h0;
                else     rk_q <= rk_comb;
            end
            assign bus.rk_data = rk_q;
        end else begin : g_rk_comb
            assign bus.rk_data = rk_comb;
        end
    endgenerate

endmodule

// File: tb/tb_aes128_key_expander.sv
// ----------------------------------------------------------------------------
// tb_aes128_key_expander
//   Self-checking bench for aes128_key_expander (RK_REG_OUT = 1). Provides the
//   external SubWord from an S-box derived from GF(2^8) inversion plus the
//   affine map, and compares round keys against a word-array key schedule.
//   Build with +define+AES_KEYEXP_ZEROIZE_EN to add the zeroize sequence.
// ----------------------------------------------------------------------------
module tb_aes128_key_expander;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes128_key_expander_if bus ();

    aes128_key_expander #(.RK_REG_OUT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]   sbox_t [256];
    logic [127:0] exp_rk [11];
    int           n_checks = 0;
    int           n_fail   = 0;

    assign bus.sub_word_out = {sbox_t[bus.sub_word_in[31:24]], sbox_t[bus.sub_word_in[23:16]],
                               sbox_t[bus.sub_word_in[15:8]],  sbox_t[bus.sub_word_in[7:0]]};

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Offers a key for one clock edge; returns at the falling edge after it.
    task automatic start_key(input logic [127:0] key);
        @(negedge clk);
        bus.key_in    = key;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {127'h0, bus.done}, 128'h1);
    endtask

    task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
        @(negedge clk);
        bus.rk_addr = a;
        @(posedge clk);
        #1 d = bus.rk_data;
    endtask

    task automatic check_all_rk(input logic [127:0] key, input string tag);
        logic [127:0] d;
        model_expand(key);
        for (int r = 0; r < 11; r++) begin
            read_rk(r[3:0], d);
            check($sformatf("%s_rk%0d", tag, r), d, exp_rk[r]);
        end
    endtask

    initial begin
        vec_t         vecs [2];
        logic [127:0] d;
        logic [127:0] key;
        int           busy_cnt, done_cnt, done_at, kr_bad, kv40, kv_early, n;

        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{128'h0,
                    128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        build_sbox();
        rst           = 1'b1;
        bus.key_in    = 128'h0;
        bus.key_valid = 1'b0;
        bus.rk_addr   = 4'd0;
`ifdef AES_KEYEXP_ZEROIZE_EN
        bus.zeroize   = 1'b0;
`endif
        #12;
        check("reset_flags", {124'h0, bus.key_ready, bus.busy, bus.done, bus.keys_valid}, 128'h8);
        check("reset_rk_data", bus.rk_data, 128'h0);
        check("reset_sub_word_in", {96'h0, bus.sub_word_in}, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // Known-answer vectors: rk[1], rk[10] and the full schedule.
        for (int v = 0; v < 2; v++) begin
            start_key(vecs[v].key);
            wait_done();
            read_rk(4'd1, d);
            check($sformatf("kat%0d_rk1", v), d, vecs[v].rk1);
            read_rk(4'd10, d);
            check($sformatf("kat%0d_rk10", v), d, vecs[v].rk10);
            check_all_rk(vecs[v].key, $sformatf("kat%0d", v));
        end

        // Latency and handshake timing of one expansion.
        key = {$urandom, $urandom, $urandom, $urandom};
        start_key(key);
        busy_cnt = 0; done_cnt = 0; done_at = -1; kr_bad = 0; kv40 = 0;
        for (int j = 0; j <= 41; j++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin done_cnt++; done_at = j; end
            if (bus.busy && bus.key_ready) kr_bad++;
            if (j == 40) kv40 = int'(bus.keys_valid);
            @(negedge clk);
        end
        check("lat_busy_cycles", busy_cnt, 40);
        check("lat_done_count", done_cnt, 1);
        check("lat_done_cycle", done_at, 40);
        check("lat_key_ready_in_expand", kr_bad, 0);
        check("lat_keys_valid_at_done", kv40, 1);
        check_all_rk(key, "lat");

        // Key offered mid-expansion is ignored.
        key = {$urandom, $urandom, $urandom, $urandom};
        start_key(key);
        repeat (9) @(negedge clk);
        bus.key_in    = ~key;
        bus.key_valid = 1'b1;
        check("mid_key_ready", {127'h0, bus.key_ready}, 128'h0);
        repeat (5) @(negedge clk);
        bus.key_valid = 1'b0;
        wait_done();
        check_all_rk(key, "ignore");

        // Re-key from DONE: keys_valid low until the new done.
        key = {$urandom, $urandom, $urandom, $urandom};
        start_key(key);
        check("rekey_kv_low", {126'h0, bus.keys_valid, bus.busy}, 128'h1);
        kv_early = 0; n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.keys_valid) kv_early++;
            @(negedge clk);
            n++;
        end
        check("rekey_done_seen", {127'h0, bus.done}, 128'h1);
        check("rekey_kv_early", kv_early, 0);
        check_all_rk(key, "rekey");

        // Reset in the middle of EXPAND, then a fresh key.
        start_key({$urandom, $urandom, $urandom, $urandom});
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_flags", {124'h0, bus.key_ready, bus.busy, bus.done, bus.keys_valid}, 128'h8);
        check("rst_mid_rk_data", bus.rk_data, 128'h0);
        check("rst_mid_sub_word_in", {96'h0, bus.sub_word_in}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        start_key(key);
        wait_done();
        check_all_rk(key, "post_rst");
        read_rk(4'd12, d);
        check("rk_addr12", d, 128'h0);
        read_rk(4'd11, d);
        check("rk_addr11", d, 128'h0);

        // Random keys against the reference schedule.
        for (int k = 0; k < 5; k++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            start_key(key);
            wait_done();
            check_all_rk(key, $sformatf("rand%0d", k));
        end

`ifdef AES_KEYEXP_ZEROIZE_EN
        // Zeroize in DONE wipes the schedule; zeroize beats key_valid.
        @(negedge clk);
        bus.zeroize = 1'b1;
        @(negedge clk);
        bus.zeroize = 1'b0;
        check("zero_flags", {124'h0, bus.key_ready, bus.busy, bus.done, bus.keys_valid}, 128'h8);
        for (int r = 1; r < 11; r++) begin
            read_rk(r[3:0], d);
            check($sformatf("zero_rk%0d", r), d, 128'h0);
        end
        @(negedge clk);
        bus.key_in    = {$urandom, $urandom, $urandom, $urandom};
        bus.key_valid = 1'b1;
        bus.zeroize   = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.zeroize   = 1'b0;
        check("zero_beats_key", {126'h0, bus.key_ready, bus.busy}, 128'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
